wca_dsp_decim_accum: RTL and testbench
======================================

Name: wca_dsp_decim_accum

Overview:
- Integrate-and-dump decimator for complex I/Q samples. Sits directly downstream of the DSP strobe generator.
- Accumulates input samples on each sample strobe. On each decimation strobe from the strobe generator, it dumps the sum, rounds and scales it, and emits one output sample with a one-cycle valid strobe.
- Also reports how many samples were in each dump and flags output saturation.

Parameters:
IN_WIDTH, 16, width of signed input I/Q samples
ACC_WIDTH, 40, width of signed accumulators; must be >= IN_WIDTH + log2(max decimation)
OUT_WIDTH, 16, width of signed output I/Q samples

Ports:
clock  in  1  system clock
reset  in  1  reset; synchronous, active-high
enable  in  1  block enable; low clears accumulation and pipeline
strobe_in  in  1  input sample valid
strobe_dump  in  1  decimation tick (strobe_out of the strobe generator)
shift  in  6  right-shift applied to the dumped sum
din_i  in  IN_WIDTH  signed I sample
din_q  in  IN_WIDTH  signed Q sample
dout_i  out  OUT_WIDTH  signed decimated I
dout_q  out  OUT_WIDTH  signed decimated Q
strobe_out  out  1  one-cycle output valid
dump_count  out  24  number of samples summed into the current dout
sat  out  1  sticky: any output sample was clipped

Behaviour:
- Reset: acc_i, acc_q, internal sample counter, stage-1 registers, dout_i, dout_q, dump_count, strobe_out and sat all go to 0. Reset has priority over every other input.
- enable=0:
  - Accumulators, sample counter and stage-1 valid are cleared; strobe_out=0.
  - dout_i, dout_q, dump_count and sat hold their values.
- Accumulate (enable=1, strobe_in=1, strobe_dump=0):
  - acc <= acc + sign_extend(din), two's-complement wrap at ACC_WIDTH.
  - Counter increments, saturating at 24'hFFFFFF.
- Dump (enable=1, strobe_dump=1), at cycle N:
  - Stage-1 registers capture acc + (strobe_in ? din : 0). A coincident sample belongs to the dumped sum.
  - Stage 1 also captures the sample count (including the coincident sample) and shift clamped to min(shift, ACC_WIDTH-1).
  - acc and the counter restart at 0; stage-1 valid is set for one cycle.
- Stage 2 (cycle N+1, when stage-1 valid):
  - rnd = (s==0) ? 0 : 1<<(s-1).
  - y = (sum + rnd) >>> s, arithmetic shift computed at ACC_WIDTH+1 bits so the rounding add cannot overflow.
  - If y > 2^(OUT_WIDTH-1)-1, output the max value and set sat. If y < -2^(OUT_WIDTH-1), output the min value and set sat. Otherwise output y[OUT_WIDTH-1:0].
  - I and Q are rounded and saturated independently.
- Outputs registered; strobe_out is high exactly during cycle N+2. Latency is 2 clocks from strobe_dump to strobe_out.
- dout_i, dout_q and dump_count update only on strobe_out and hold between strobes.
- Dump with no samples accumulated: outputs 0, dump_count=0, strobe_out still pulses.
- Back-to-back dumps (strobe_dump high on consecutive cycles) are legal. Each produces its own strobe_out, one per cycle, in order. The pipeline never stalls.
- enable falling while stage 1 is valid: that pending output is discarded (no strobe_out).
- sat is cleared only by reset.
- shift is sampled only at dump time; changes between dumps affect only later dumps.

Test Plan:
- Reset then idle: all outputs 0, strobe_out never asserts over 100 cycles.
- Sum of 4 samples din_i=1000, din_q=-1000 with strobe_in every cycle, strobe_dump coincident with the 4th sample, shift=2 -> 2 cycles later strobe_out=1 for one cycle, dout_i=1000, dout_q=-1000, dump_count=4, sat=0.
- Rounding: sum 6 with shift=2 -> dout=2 (6+2=8, >>2). Sum -6 with shift=2 -> dout=-1 ((-6+2)>>>2 = -4>>>2 = -1).
- Saturation: 8 samples of 32767 with shift=0 -> dout_i=32767, sat=1 and stays 1 through later unclipped outputs until reset. 8 samples of -32768 -> dout=-32768.
- Back-to-back: strobe_dump high 3 consecutive cycles with strobe_in high, din_i=5, 7, 9, shift=0 -> three consecutive strobe_out pulses with dout_i=5, 7, 9 and dump_count=1 each.
- enable dropped to 0 one cycle after strobe_dump -> no strobe_out, dout_i holds its prior value. After re-enable, accumulation starts from 0.

Source files
------------

// File: rtl/wca_dsp_decim_accum.sv
// Integrate-and-dump decimator for complex I/Q samples: accumulates on strobe_in,
// dumps on strobe_dump, then rounds, shifts and saturates in a two-stage pipeline.
module wca_dsp_decim_accum #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        strobe_in,
    input  logic                        strobe_dump,
    input  logic [5:0]                  shift,
    input  logic signed [IN_WIDTH-1:0]  din_i,
    input  logic signed [IN_WIDTH-1:0]  din_q,
    output logic signed [OUT_WIDTH-1:0] dout_i,
    output logic signed [OUT_WIDTH-1:0] dout_q,
    output logic                        strobe_out,
    output logic [23:0]                 dump_count,
    output logic                        sat
);

    localparam int EXT_WIDTH = ACC_WIDTH + 1;
    localparam logic [5:0] SHIFT_MAX = 6'(ACC_WIDTH - 1);
    localparam logic signed [EXT_WIDTH-1:0] OUT_MAX =
        {{(EXT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] OUT_MIN =
        {{(EXT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [23:0] COUNT_MAX = 24'hFFFFFF;

    // Channel 0 is I, channel 1 is Q; both share the counter and control path.
    logic signed [IN_WIDTH-1:0]  din_ch [2];
    logic signed [OUT_WIDTH-1:0] dout_reg [2];
    logic                        sat_hit [2];

    assign din_ch[0] = din_i;
    assign din_ch[1] = din_q;
    assign dout_i    = dout_reg[0];
    assign dout_q    = dout_reg[1];

    logic [23:0] count_reg;
    logic [23:0] count_inc;
    logic [23:0] s1_count_reg;
    logic [5:0]  s1_shift_reg;
    logic [5:0]  shift_clamped;
    logic        s1_valid_reg;

    assign count_inc     = (count_reg == COUNT_MAX) ? count_reg : count_reg + 24'd1;
    assign shift_clamped = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg    <= '0;
            s1_count_reg <= '0;
            s1_shift_reg <= '0;
            s1_valid_reg <= 1'b0;
            strobe_out   <= 1'b0;
            dump_count   <= '0;
            sat          <= 1'b0;
        end else if (!enable) begin
            // Dropping enable discards anything pending in stage 1.
            count_reg    <= '0;
            s1_valid_reg <= 1'b0;
            strobe_out   <= 1'b0;
        end else begin
            strobe_out   <= s1_valid_reg;
            s1_valid_reg <= strobe_dump;
            if (s1_valid_reg) begin
                dump_count <= s1_count_reg;
                sat        <= sat | sat_hit[0] | sat_hit[1];
            end
            if (strobe_dump) begin
                s1_count_reg <= strobe_in ? count_inc : count_reg;
                s1_shift_reg <= shift_clamped;
                count_reg    <= '0;
            end else if (strobe_in) begin
                count_reg <= count_inc;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic signed [ACC_WIDTH-1:0] acc_reg;
        logic signed [ACC_WIDTH-1:0] s1_sum_reg;
        logic signed [ACC_WIDTH-1:0] din_ext;
        logic signed [ACC_WIDTH-1:0] sum_next;
        logic signed [EXT_WIDTH-1:0] sum_ext;
        logic signed [EXT_WIDTH-1:0] rnd;
        logic signed [EXT_WIDTH-1:0] y;
        logic signed [OUT_WIDTH-1:0] out_next;
        logic                        hit;

        assign din_ext  = {{(ACC_WIDTH-IN_WIDTH){din_ch[gi][IN_WIDTH-1]}}, din_ch[gi]};
        assign sum_next = acc_reg + (strobe_in ? din_ext : '0);

        // One extra bit of headroom keeps the rounding add from overflowing.
        always_comb begin
            sum_ext  = {s1_sum_reg[ACC_WIDTH-1], s1_sum_reg};
            rnd      = '0;
            if (s1_shift_reg != 6'd0)
                rnd = {{(EXT_WIDTH-1){1'b0}}, 1'b1} << (s1_shift_reg - 6'd1);
            y        = (sum_ext + rnd) >>> s1_shift_reg;
            out_next = y[OUT_WIDTH-1:0];
            hit      = 1'b0;
            if (y > OUT_MAX) begin
                out_next = OUT_MAX[OUT_WIDTH-1:0];
                hit      = 1'b1;
            end else if (y < OUT_MIN) begin
                out_next = OUT_MIN[OUT_WIDTH-1:0];
                hit      = 1'b1;
            end
        end

        assign sat_hit[gi] = hit;

        always_ff @(posedge clock) begin
            if (reset) begin
                acc_reg      <= '0;
                s1_sum_reg   <= '0;
                dout_reg[gi] <= '0;
            end else if (!enable) begin
                acc_reg <= '0;
            end else begin
                if (strobe_dump) begin
                    s1_sum_reg <= sum_next;
                    acc_reg    <= '0;
                end else if (strobe_in) begin
                    acc_reg <= sum_next;
                end
                if (s1_valid_reg)
                    dout_reg[gi] <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_wca_dsp_decim_accum.sv
// Scoreboard bench for wca_dsp_decim_accum: directed I/Q vectors push expected
// dumps into a queue; a negedge monitor pops and checks each strobe_out.
module tb_wca_dsp_decim_accum;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               strobe_in;
    logic               strobe_dump;
    logic [5:0]         shift;
    logic signed [15:0] din_i;
    logic signed [15:0] din_q;
    logic signed [15:0] dout_i;
    logic signed [15:0] dout_q;
    logic               strobe_out;
    logic [23:0]        dump_count;
    logic               sat;

    wca_dsp_decim_accum #(.IN_WIDTH(16), .ACC_WIDTH(40), .OUT_WIDTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .strobe_in   (strobe_in),
        .strobe_dump (strobe_dump),
        .shift       (shift),
        .din_i       (din_i),
        .din_q       (din_q),
        .dout_i      (dout_i),
        .dout_q      (dout_q),
        .strobe_out  (strobe_out),
        .dump_count  (dump_count),
        .sat         (sat)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ei;
        int eq;
        int ec;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic en, input logic si, input logic sd, input int sh,
                         input int di, input int dq,
                         input logic push, input int ei, input int eq, input int ec);
        exp_t e;
        @(negedge clock);
        enable      = en;
        strobe_in   = si;
        strobe_dump = sd;
        shift       = 6'(sh);
        din_i       = 16'(di);
        din_q       = 16'(dq);
        if (push) begin
            e.ei  = ei;
            e.eq  = eq;
            e.ec  = ec;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    // Monitor: every strobe_out must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && strobe_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout_i", int'(dout_i), e.ei);
                chk("dout_q", int'(dout_q), e.eq);
                chk("dump_count", int'(dump_count), e.ec);
                chk("latency", cyc - e.cyc, 2);
                $display("out: dout_i=%0d dout_q=%0d count=%0d sat=%0d", dout_i, dout_q,
                         dump_count, sat);
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; strobe_in = 1'b0; strobe_dump = 1'b0;
        shift = '0; din_i = '0; din_q = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_dout_i", int'(dout_i), 0);
        chk("reset_dout_q", int'(dout_q), 0);
        chk("reset_count", int'(dump_count), 0);
        chk("reset_sat", int'(sat), 0);
        chk("reset_strobe", int'(strobe_out), 0);

        // Idle: the monitor flags any strobe as unexpected.
        idle(100);

        // Four samples of +/-1000, dump on the fourth, shift 2.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, 2, 1000, -1000, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 2, 1000, -1000, 1'b1, 1000, -1000, 4);
        idle(3);
        chk("sat_after_basic", int'(sat), 0);

        // Rounding: sum 6 -> 2, sum -6 -> -1 at shift 2.
        drive(1'b1, 1'b1, 1'b0, 2, 3, -3, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 2, 3, -3, 1'b1, 2, -1, 2);
        idle(3);

        // Shift is taken at dump time: (5+1)>>1=3, (-5+1)>>>1=-2 even though shift changes next.
        drive(1'b1, 1'b1, 1'b1, 1, 5, -5, 1'b1, 3, -2, 1);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
        idle(3);

        // Saturation both directions, then an unclipped output keeps sat set.
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b0, 0, 32767, -32768, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 0, 32767, -32768, 1'b1, 32767, -32768, 8);
        idle(3);
        chk("sat_set", int'(sat), 1);
        drive(1'b1, 1'b1, 1'b1, 0, 10, -10, 1'b1, 10, -10, 1);
        idle(3);
        chk("sat_sticky", int'(sat), 1);

        // Back-to-back dumps, one sample each.
        drive(1'b1, 1'b1, 1'b1, 0, 5, -5, 1'b1, 5, -5, 1);
        drive(1'b1, 1'b1, 1'b1, 0, 7, -7, 1'b1, 7, -7, 1);
        drive(1'b1, 1'b1, 1'b1, 0, 9, -9, 1'b1, 9, -9, 1);
        idle(4);

        // Enable drops one cycle after the dump: output discarded, dout holds.
        drive(1'b1, 1'b1, 1'b0, 0, 100, 100, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 0, 100, 100, 1'b0, 0, 0, 0);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
        chk("hold_dout_i", int'(dout_i), 9);
        chk("hold_count", int'(dump_count), 1);

        // After re-enable the accumulator starts from zero.
        drive(1'b1, 1'b1, 1'b1, 0, 4, -4, 1'b1, 4, -4, 1);
        idle(2);
        // Empty dump still strobes with zeros.
        drive(1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b1, 0, 0, 0);
        idle(3);
        chk("sat_final", int'(sat), 1);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
        chk("pending_expectations", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
